// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   md_op_e    : operation encoding, identical to the M-extension funct3 field
//   md_state_e : control FSM states
//   XLEN_DEF   : default operand/result width
//   RST_RESULT : value the result register takes while in reset
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam int          XLEN_DEF   = 32;
  localparam logic [31:0] RST_RESULT = 32'hDEADBEEF;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle.
// Operands arrive from the register file read ports when decode issues an
// M-type op; result and destination index go to the write-back mux.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      issue request, accepted only in IDLE
//   flush      abort the op in flight (ignored once the op has completed)
//   funct3     operation select (md_op_e encoding)
//   operand_a  rs1 value
//   operand_b  rs2 value
//   rd_in      destination register index
//   busy       high while an op is in CALC or DONE
//   done       one-cycle pulse, result valid
//   result     op result, held until the next accepted start completes
//   rd_out     destination index captured at start
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_e         state, state_nxt;
  md_op_e            op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mag_b;
  logic              neg_q;
  logic              rem_neg_q;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              last;

  // Issue-side decode on the raw register-file operands
  md_op_e          op_in;
  logic            a_signed_in, b_signed_in;
  logic            sa_in, sb_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    op_in       = md_op_e'(funct3);
    a_signed_in = (op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM);
    b_signed_in = (op_in == MULH) || (op_in == DIV) || (op_in == REM);
    sa_in       = a_signed_in & operand_a[XLEN-1];
    sb_in       = b_signed_in & operand_b[XLEN-1];
    mag_a_in    = sa_in ? -operand_a : operand_a;
    mag_b_in    = sb_in ? -operand_b : operand_b;
    div_zero    = funct3[2] && (operand_b == '0);
    div_ovf     = ((op_in == DIV) || (op_in == REM)) &&
                  (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
    fast        = div_zero | div_ovf;
    // funct3[1] separates remainder ops from quotient ops
    if (div_zero) fast_result = funct3[1] ? operand_a : '1;
    else          fast_result = funct3[1] ? '0 : operand_a;
  end

  // Shared adder/subtractor. Multiply adds the multiplicand into the upper
  // half; divide subtracts the divisor from the left-shifted partial
  // remainder. Because the partial remainder is always below the divisor,
  // bit XLEN of the subtraction is set exactly when it would go negative.
  logic            is_div_q;
  logic [XLEN:0]   add_a, add_b, add_sum;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    is_div_q = op_q[2];
    add_a    = is_div_q ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
    add_b    = {1'b0, mag_b};
    add_sum  = add_a + (is_div_q ? ~add_b : add_b) + {{XLEN{1'b0}}, is_div_q};
    if (is_div_q) begin
      if (!add_sum[XLEN]) acc_step = {add_sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                acc_step = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {add_sum, acc[XLEN-1:1]};
      else        acc_step = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  // Sign post-processing of the final accumulator
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, calc_result;

  always_comb begin
    prod        = neg_q ? -acc_step : acc_step;
    quo         = acc_step[XLEN-1:0];
    rem         = acc_step[2*XLEN-1:XLEN];
    calc_result = prod[XLEN-1:0];
    case (op_q)
      MUL:                  calc_result = prod[XLEN-1:0];
      MULH, MULHSU, MULHU:  calc_result = prod[2*XLEN-1:XLEN];
      DIV, DIVU:            calc_result = neg_q ? -quo : quo;
      REM, REMU:            calc_result = rem_neg_q ? -rem : rem;
      default:              calc_result = prod[XLEN-1:0];
    endcase
  end

  // Control FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        accept = start & ~flush;
        if (accept) state_nxt = fast ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        last = (cnt == CNT_W'(XLEN-1));
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one iteration per CALC cycle;
  // result is written on the edge that enters DONE so it is valid with done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= MUL;
      acc       <= '0;
      mag_b     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt       <= '0;
      result    <= RST_RESULT[XLEN-1:0];
      rd_out    <= '0;
    end else if (accept) begin
      op_q      <= op_in;
      acc       <= {{XLEN{1'b0}}, mag_a_in};
      mag_b     <= mag_b_in;
      neg_q     <= sa_in ^ sb_in;
      rem_neg_q <= sa_in;
      cnt       <= '0;
      rd_out    <= rd_in;
      if (fast) result <= fast_result;
    end else if ((state == CALC) && !flush) begin
      acc <= acc_step;
      cnt <= cnt + CNT_W'(1);
      if (last) result <= calc_result;
    end
  end

endmodule
